sprite_row_prefetch: RTL and testbench
======================================

SPRITE_ROW_PREFETCH -- requirements
Module: sprite_row_prefetch

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  X  10'd0  sprite left column in screen pixels
  Y  10'd0  sprite top row in screen pixels
  BASE  20'h00000  SRAM word address of sprite row 0, word 0
REQ-002 Ports, one per line (name, direction, width, meaning):
  CLK  in  1  pixel clock, all state on rising edge
  Reset  in  1  synchronous, active-high reset
  DrawX  in  10  current scan column, 0..799
  DrawY  in  10  current scan row, 0..524
  SRAM_DQ  in  16  SRAM read data
  SRAM_ADDR  out  20  SRAM word address
  CE  out  1  SRAM chip enable, active-low
  OE  out  1  SRAM output enable, active-low
  UB  out  1  SRAM upper-byte enable, active-low
  LB  out  1  SRAM lower-byte enable, active-low
  WE  out  1  SRAM write enable, active-low, held 1 (read-only block)
  busy  out  1  high while a row fetch is in progress
  pix_idx  out  4  palette index of the sprite pixel at the current DrawX/DrawY
  pix_valid  out  1  pix_idx is an opaque sprite pixel

Function
REQ-003 Sprite geometry: 64x64 pixels, 4 bpp, 16 SRAM words per row; word w holds pixels 4w..4w+3, pixel 4w in bits [3:0], pixel 4w+3 in bits [15:12].
REQ-004 Storage: two banks of 16x16-bit words (ping-pong); each bank has a valid flag; disp_bank selects the bank read for display, the other bank is the fill bank.
REQ-005 FSM states IDLE, FETCH, DRAIN; reset state IDLE.
REQ-006 Trigger: in IDLE, on a cycle with DrawX==640, compute nextY = (DrawY==524) ? 0 : DrawY+1; if Y <= nextY <= Y+63, set row = nextY-Y and go to FETCH; otherwise clear the fill-bank valid flag and stay in IDLE.
REQ-007 FETCH: issue word addresses w=0..15 on consecutive cycles, SRAM_ADDR = BASE + row*16 + w (20-bit, wrap modulo 2^20); CE=OE=UB=LB=0 throughout FETCH and DRAIN.
REQ-008 Read latency is one cycle: SRAM_DQ sampled on the cycle after address w is driven and written to fill-bank word w.
REQ-009 After address 15 is issued go to DRAIN for one cycle to capture word 15, set the fill-bank valid flag, then return to IDLE; total fetch = 17 cycles from FETCH entry.
REQ-010 busy = 1 exactly in FETCH and DRAIN.
REQ-011 In IDLE, CE=OE=UB=LB=1 and SRAM_ADDR holds its last value; WE=1 at all times.
REQ-012 Bank swap: on every cycle with DrawX==799, disp_bank toggles; swap is unconditional, independent of FSM state.
REQ-013 A trigger arriving while busy is ignored (cannot occur in legal timing: 17 < 160 cycles of blanking).
REQ-014 Display: when DrawY in [Y, Y+63], DrawX in [X, X+63] and disp-bank valid, dx = DrawX-X, nibble = word[dx>>2] bits [4*dx[1:0]+3 : 4*dx[1:0]].
REQ-015 pix_idx and pix_valid are registered: one-cycle latency relative to DrawX/DrawY; pix_valid = 1 only when REQ-014 conditions hold and nibble != 0 (index 0 is transparent); pix_idx = nibble when pix_valid, else 0.
REQ-016 Comparisons use 11-bit arithmetic so that X+63 or Y+63 beyond 10 bits does not wrap; sprite partly off-screen is clipped, never wrapped.

Reset
REQ-017 Reset (synchronous, active-high, priority over all other logic): state IDLE, busy=0, CE=OE=UB=LB=WE=1, SRAM_ADDR=0, pix_idx=0, pix_valid=0, disp_bank=0, both valid flags 0.
REQ-018 Reset asserted mid-fetch aborts the fetch; no further words are written and the partly filled bank remains invalid.
REQ-019 Buffer word contents need not be reset.

Verification (X=100, Y=50, BASE=20'h01000)
REQ-020 Reset for 2 cycles -> all outputs at REQ-017 values; no SRAM strobe until first in-range trigger.
REQ-021 DrawY=49, DrawX=640 -> busy rises next cycle; SRAM_ADDR 20'h01000..20'h0100F on 16 consecutive cycles; busy high 17 cycles.
REQ-022 SRAM model returns word w = 16'h4321 for all w; after swap at DrawX=799, line DrawY=50: DrawX=100 -> next cycle pix_idx=1, pix_valid=1; DrawX=103 -> pix_idx=4; DrawX=99 and 164 -> pix_valid=0.
REQ-023 Word 0 = 16'h0050 -> DrawX=100 pix_valid=0 (transparent), DrawX=101 pix_idx=5, DrawX=102 pix_valid=0.
REQ-024 DrawY=113, DrawX=640 (nextY=114 out of range) -> no fetch, busy=0; line 114 shows pix_valid=0 throughout. DrawY=524 with Y=0 -> fetch row 0, SRAM_ADDR starts at BASE.
REQ-025 Reset asserted on the 8th FETCH cycle -> busy=0 next cycle, CE=1; following line shows pix_valid=0 everywhere.

Source files
------------

// File: rtl/sprite_row_prefetch.sv
// Ping-pong row prefetcher for a 64x64, 4 bpp sprite held in SRAM.
// The row for the next scan line is fetched in horizontal blanking and swapped in at the end of the line.
module sprite_row_prefetch #(
  parameter logic [9:0]  X    = 10'd0,
  parameter logic [9:0]  Y    = 10'd0,
  parameter logic [19:0] BASE = 20'h00000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [15:0] SRAM_DQ,
  output logic [19:0] SRAM_ADDR,
  output logic        CE,
  output logic        OE,
  output logic        UB,
  output logic        LB,
  output logic        WE,
  output logic        busy,
  output logic [3:0]  pix_idx,
  output logic        pix_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state_q;
  logic [3:0]  word_q;
  logic [5:0]  row_q;
  logic [19:0] addr_q;
  logic        strobe_n_q;
  logic        busy_q;
  logic        disp_bank_q;
  logic [1:0]  valid_q;
  logic [15:0] buf_q [0:31];
  logic [3:0]  pix_idx_q;
  logic        pix_valid_q;

  logic [9:0]  next_y_d;
  logic [5:0]  row_d;
  logic        fetch_hit_d;
  logic        fill_bank_d;
  logic        wr_en_d;
  logic [3:0]  wr_idx_d;
  logic [5:0]  dx_d;
  logic [15:0] word_d;
  logic [3:0]  nibble_d;
  logic        in_win_d;
  logic        pix_valid_d;
  logic [3:0]  pix_idx_d;

  // 11-bit window bounds so a sprite near the screen edge is clipped rather than wrapped
  always_comb begin
    next_y_d    = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
    row_d       = next_y_d[5:0] - Y[5:0];
    fetch_hit_d = ({1'b0, next_y_d} >= {1'b0, Y}) &&
                  ({1'b0, next_y_d} <= ({1'b0, Y} + 11'd63));
    fill_bank_d = ~disp_bank_q;
    wr_en_d     = !Reset && (((state_q == FETCH) && (word_q != 4'd0)) || (state_q == DRAIN));
    wr_idx_d    = (state_q == DRAIN) ? 4'd15 : word_q - 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      word_q      <= 4'd0;
      row_q       <= 6'd0;
      addr_q      <= 20'h00000;
      strobe_n_q  <= 1'b1;
      busy_q      <= 1'b0;
      disp_bank_q <= 1'b0;
      valid_q     <= 2'b00;
    end else begin
      if (DrawX == 10'd799) begin
        disp_bank_q <= ~disp_bank_q;
      end
      case (state_q)
        IDLE: begin
          if (DrawX == 10'd640) begin
            valid_q[fill_bank_d] <= 1'b0;
            if (fetch_hit_d) begin
              state_q    <= FETCH;
              row_q      <= row_d;
              word_q     <= 4'd0;
              addr_q     <= BASE + {10'd0, row_d, 4'd0};
              strobe_n_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (word_q == 4'd15) begin
            state_q <= DRAIN;
          end else begin
            word_q <= word_q + 4'd1;
            addr_q <= BASE + {10'd0, row_q, word_q + 4'd1};
          end
        end
        DRAIN: begin
          valid_q[fill_bank_d] <= 1'b1;
          state_q    <= IDLE;
          strobe_n_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          strobe_n_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Data for address w arrives one cycle later, so the write index trails the issued word by one
  always_ff @(posedge CLK) begin
    if (wr_en_d) begin
      buf_q[{fill_bank_d, wr_idx_d}] <= SRAM_DQ;
    end
  end

  always_comb begin
    dx_d        = DrawX[5:0] - X[5:0];
    word_d      = buf_q[{disp_bank_q, dx_d[5:2]}];
    nibble_d    = word_d[{dx_d[1:0], 2'b00} +: 4];
    in_win_d    = ({1'b0, DrawX} >= {1'b0, X}) && ({1'b0, DrawX} <= ({1'b0, X} + 11'd63)) &&
                  ({1'b0, DrawY} >= {1'b0, Y}) && ({1'b0, DrawY} <= ({1'b0, Y} + 11'd63));
    pix_valid_d = in_win_d && valid_q[disp_bank_q] && (nibble_d != 4'd0);
    pix_idx_d   = pix_valid_d ? nibble_d : 4'd0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pix_idx_q   <= 4'd0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_idx_q   <= pix_idx_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign SRAM_ADDR = addr_q;
  assign CE        = strobe_n_q;
  assign OE        = strobe_n_q;
  assign UB        = strobe_n_q;
  assign LB        = strobe_n_q;
  assign WE        = 1'b1;
  assign busy      = busy_q;
  assign pix_idx   = pix_idx_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_sprite_row_prefetch.sv
// Directed bench for sprite_row_prefetch with X=100, Y=50, BASE=20'h01000 plus a Y=0 instance for the row-524 wrap.
module tb_sprite_row_prefetch;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [15:0] SRAM_DQ = 16'h0000;
  logic [19:0] SRAM_ADDR;
  logic        CE, OE, UB, LB, WE, busy, pix_valid;
  logic [3:0]  pix_idx;

  logic [19:0] addr0;
  logic        ce0, oe0, ub0, lb0, we0, busy0, pv0;
  logic [3:0]  pi0;

  logic [15:0] sram_words [0:15];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          busy_cnt;

  always #5 CLK = ~CLK;

  sprite_row_prefetch #(.X(10'd100), .Y(10'd50), .BASE(20'h01000)) u_dut (
    .CLK(CLK), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR), .CE(CE), .OE(OE), .UB(UB), .LB(LB), .WE(WE),
    .busy(busy), .pix_idx(pix_idx), .pix_valid(pix_valid)
  );

  sprite_row_prefetch #(.X(10'd100), .Y(10'd0), .BASE(20'h01000)) u_dut_y0 (
    .CLK(CLK), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDR(addr0), .CE(ce0), .OE(oe0), .UB(ub0), .LB(lb0), .WE(we0),
    .busy(busy0), .pix_idx(pi0), .pix_valid(pv0)
  );

  // One-cycle-latency SRAM: data for the address seen at an edge is on the bus for the following cycle
  always @(posedge CLK) begin
    SRAM_DQ <= sram_words[SRAM_ADDR[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix_at(input logic [9:0] y, input logic [9:0] x, input logic v, input logic [3:0] idx,
                        input string tag);
    DrawY = y;
    DrawX = x;
    tick();
    check({tag, "_valid"}, {31'd0, pix_valid}, {31'd0, v});
    check({tag, "_idx"}, {28'd0, pix_idx}, {28'd0, idx});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sram_words[i] = 16'h4321;
    Reset = 1'b1;
    DrawX = 10'd0;
    DrawY = 10'd0;
    ticks(2);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {27'd0, CE, OE, UB, LB, WE}, 32'h1F);
    check("rst_addr", {12'd0, SRAM_ADDR}, 32'd0);
    check("rst_pix", {27'd0, pix_valid, pix_idx}, 32'd0);
    Reset = 1'b0;
    tick();
    check("idle_ce", {31'd0, CE}, 32'd1);

    // Row 0 fetch for line 50
    DrawY = 10'd49;
    DrawX = 10'd640;
    tick();
    DrawX = 10'd641;
    check("fetch_addr0", {12'd0, SRAM_ADDR}, 32'h01000);
    check("fetch_strobes", {27'd0, CE, OE, UB, LB, WE}, 32'h01);
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (i <= 15) check($sformatf("fetch_addr%0d", i), {12'd0, SRAM_ADDR}, 32'h01000 + i);
      if (busy) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, 32'd17);
    check("post_fetch_ce", {31'd0, CE}, 32'd1);
    check("post_fetch_addr_hold", {12'd0, SRAM_ADDR}, 32'h0100F);

    DrawX = 10'd799;
    tick();
    pix_at(10'd50, 10'd100, 1'b1, 4'd1, "l50_x100");
    pix_at(10'd50, 10'd103, 1'b1, 4'd4, "l50_x103");
    pix_at(10'd50, 10'd101, 1'b1, 4'd2, "l50_x101");
    pix_at(10'd50, 10'd99,  1'b0, 4'd0, "l50_x99");
    pix_at(10'd50, 10'd164, 1'b0, 4'd0, "l50_x164");
    pix_at(10'd50, 10'd163, 1'b1, 4'd4, "l50_x163");

    // Row 1 with a transparent nibble in word 0
    sram_words[0] = 16'h0050;
    DrawY = 10'd50;
    DrawX = 10'd640;
    tick();
    DrawX = 10'd641;
    check("row1_addr0", {12'd0, SRAM_ADDR}, 32'h01010);
    ticks(18);
    DrawX = 10'd799;
    tick();
    pix_at(10'd51, 10'd100, 1'b0, 4'd0, "l51_x100");
    pix_at(10'd51, 10'd101, 1'b1, 4'd5, "l51_x101");
    pix_at(10'd51, 10'd102, 1'b0, 4'd0, "l51_x102");
    pix_at(10'd51, 10'd104, 1'b1, 4'd1, "l51_x104");

    // Next line out of range: no fetch, swapped-in bank invalid
    DrawY = 10'd113;
    DrawX = 10'd640;
    tick();
    DrawX = 10'd641;
    check("oor_busy", {31'd0, busy}, 32'd0);
    check("oor_ce", {31'd0, CE}, 32'd1);
    ticks(3);
    DrawX = 10'd799;
    tick();
    pix_at(10'd114, 10'd101, 1'b0, 4'd0, "l114_x101");
    pix_at(10'd114, 10'd130, 1'b0, 4'd0, "l114_x130");
    pix_at(10'd60,  10'd101, 1'b0, 4'd0, "invalid_bank");

    // Frame wrap: line 524 prefetches row 0 of a Y=0 sprite
    DrawY = 10'd524;
    DrawX = 10'd640;
    tick();
    DrawX = 10'd641;
    check("wrap_busy", {31'd0, busy0}, 32'd1);
    check("wrap_addr", {12'd0, addr0}, 32'h01000);
    check("wrap_main_idle", {31'd0, busy}, 32'd0);
    ticks(18);

    // Reset in the 8th fetch cycle
    DrawY = 10'd49;
    DrawX = 10'd640;
    tick();
    DrawX = 10'd641;
    ticks(7);
    check("abort_pre_addr", {12'd0, SRAM_ADDR}, 32'h01007);
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ce", {31'd0, CE}, 32'd1);
    ticks(3);
    check("abort_stays_idle", {31'd0, busy}, 32'd0);
    DrawX = 10'd799;
    tick();
    pix_at(10'd50, 10'd100, 1'b0, 4'd0, "abort_x100");
    pix_at(10'd50, 10'd103, 1'b0, 4'd0, "abort_x103");
    pix_at(10'd50, 10'd140, 1'b0, 4'd0, "abort_x140");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
